// File: rtl/mos6502s_reg_sequencer.sv
// A/X/Y register micro-op sequencer: IDLE -> OPER -> WRITE, one command per 3 cycles.
// Define MOS6502S_REGSEQ_INCDEC_EN to enable INX/DEX/INY/DEY (ops 7-10); otherwise they are illegal.
module mos6502s_reg_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [7:0] a_in,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    output logic [7:0] reg_data,
    output logic       load_a,
    output logic       load_x,
    output logic       load_y,
    output logic       flag_we,
    output logic       flag_n,
    output logic       flag_z,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPER  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] D_NONE = 2'd0;
    localparam logic [1:0] D_A    = 2'd1;
    localparam logic [1:0] D_X    = 2'd2;
    localparam logic [1:0] D_Y    = 2'd3;

    logic [1:0] state;
    logic [3:0] op_q;
    logic [7:0] data_q;
    logic [7:0] res;
    logic [1:0] dest;
    logic       op_legal;

    always_comb begin
        op_legal = (cmd_op <= 4'd6) || (cmd_op == 4'd11);
`ifdef MOS6502S_REGSEQ_INCDEC_EN
        if (cmd_op >= 4'd7 && cmd_op <= 4'd10)
            op_legal = 1'b1;
`endif
    end

    // Sources are sampled in OPER, so the previous WRITE has already landed in the register file.
    always_comb begin
        res  = 8'h00;
        dest = D_NONE;
        case (op_q)
            4'd0:  begin res = data_q; dest = D_A; end
            4'd1:  begin res = data_q; dest = D_X; end
            4'd2:  begin res = data_q; dest = D_Y; end
            4'd3:  begin res = a_in;   dest = D_X; end
            4'd4:  begin res = a_in;   dest = D_Y; end
            4'd5:  begin res = x_in;   dest = D_A; end
            4'd6:  begin res = y_in;   dest = D_A; end
`ifdef MOS6502S_REGSEQ_INCDEC_EN
            4'd7:  begin res = x_in + 8'd1; dest = D_X; end
            4'd8:  begin res = x_in - 8'd1; dest = D_X; end
            4'd9:  begin res = y_in + 8'd1; dest = D_Y; end
            4'd10: begin res = y_in - 8'd1; dest = D_Y; end
`endif
            default: begin res = 8'h00; dest = D_NONE; end
        endcase
    end

    assign cmd_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= 4'd0;
            data_q   <= 8'h00;
            reg_data <= 8'h00;
            load_a   <= 1'b0;
            load_x   <= 1'b0;
            load_y   <= 1'b0;
            flag_we  <= 1'b0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            load_a  <= 1'b0;
            load_x  <= 1'b0;
            load_y  <= 1'b0;
            flag_we <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            op_q   <= cmd_op;
                            data_q <= cmd_data;
                            state  <= S_OPER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_OPER: begin
                    // Outputs are registered here so they are high exactly during WRITE.
                    state <= S_WRITE;
                    done  <= 1'b1;
                    if (dest != D_NONE) begin
                        reg_data <= res;
                        load_a   <= (dest == D_A);
                        load_x   <= (dest == D_X);
                        load_y   <= (dest == D_Y);
                        flag_we  <= 1'b1;
                        flag_n   <= res[7];
                        flag_z   <= (res == 8'h00);
                    end
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mos6502s_reg_sequencer.sv
// Directed bench for mos6502s_reg_sequencer with a small A/X/Y register-file model.
module tb_mos6502s_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] reg_data;
    logic       load_a, load_x, load_y, flag_we, flag_n, flag_z, done, err;

    logic [7:0] ra = 8'h00, rx = 8'h00, ry = 8'h00;
    int checks = 0;
    int failures = 0;
    int load_y_cnt = 0;
    int multi_cnt = 0;

    always #5 clk = ~clk;

    mos6502s_reg_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .a_in(ra), .x_in(rx), .y_in(ry),
        .reg_data(reg_data), .load_a(load_a), .load_x(load_x), .load_y(load_y),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (load_a) ra <= reg_data;
        if (load_x) rx <= reg_data;
        if (load_y) ry <= reg_data;
        if (load_y) load_y_cnt <= load_y_cnt + 1;
    end

    always @(negedge clk)
        if ((int'(load_a) + int'(load_x) + int'(load_y)) > 1) multi_cnt <= multi_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] d,
                           input logic [2:0] exp_ld, input logic exp_fw,
                           input logic [7:0] exp_d, input logic exp_n, input logic exp_z);
        @(negedge clk);
        chk({tag, "_rdy_T"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_rdy_T1"}, cmd_ready, 0);
        chk({tag, "_strb_T1"}, {load_a, load_x, load_y, flag_we, done}, 0);
        @(negedge clk);
        chk({tag, "_rdy_T2"}, cmd_ready, 0);
        chk({tag, "_load"}, {load_a, load_x, load_y}, exp_ld);
        chk({tag, "_fwe"}, flag_we, exp_fw);
        chk({tag, "_done"}, done, 1);
        if (exp_fw) begin
            chk({tag, "_data"}, reg_data, exp_d);
            chk({tag, "_nz"}, {flag_n, flag_z}, {exp_n, exp_z});
        end
        @(negedge clk);
        chk({tag, "_rdy_T3"}, cmd_ready, 1);
        chk({tag, "_idle_strb"}, {load_a, load_x, load_y, flag_we, done}, 0);
    endtask

    task automatic run_illegal(input string tag, input logic [3:0] op);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = 8'hA5;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_err"}, err, 1);
        chk({tag, "_rdy"}, cmd_ready, 1);
        chk({tag, "_strb"}, {load_a, load_x, load_y, flag_we, done}, 0);
        @(negedge clk);
        chk({tag, "_err_off"}, err, 0);
        chk({tag, "_strb2"}, {load_a, load_x, load_y, flag_we, done}, 0);
    endtask

    logic [3:0] ops [4];
    logic [7:0] dats [4];
    int acc [4];
    logic [7:0] exp_a;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {reg_data, load_a, load_x, load_y, flag_we, flag_n, flag_z, done, err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", cmd_ready, 1);
        chk("rst_data", reg_data, 0);

        run_cmd("lda80", 4'd0, 8'h80, 3'b100, 1, 8'h80, 1, 0);
        run_cmd("lda00", 4'd0, 8'h00, 3'b100, 1, 8'h00, 0, 1);
        run_cmd("ldy5a", 4'd2, 8'h5A, 3'b001, 1, 8'h5A, 0, 0);
        run_cmd("tax",   4'd3, 8'hFF, 3'b010, 1, 8'h00, 0, 1);
        run_cmd("tya",   4'd6, 8'h00, 3'b100, 1, 8'h5A, 0, 0);
        run_cmd("txa",   4'd5, 8'h00, 3'b100, 1, 8'h00, 0, 1);
`ifdef MOS6502S_REGSEQ_INCDEC_EN
        run_cmd("ldxff", 4'd1, 8'hFF, 3'b010, 1, 8'hFF, 1, 0);
        run_cmd("inx",   4'd7, 8'h00, 3'b010, 1, 8'h00, 0, 1);
        run_cmd("dex",   4'd8, 8'h00, 3'b010, 1, 8'hFF, 1, 0);
        run_cmd("ldy00", 4'd2, 8'h00, 3'b001, 1, 8'h00, 0, 1);
        run_cmd("dey",   4'd10, 8'h00, 3'b001, 1, 8'hFF, 1, 0);
        run_cmd("iny",   4'd9, 8'h00, 3'b001, 1, 8'h00, 0, 1);
`else
        run_illegal("inx_off", 4'd7);
        run_illegal("dey_off", 4'd10);
`endif
        run_illegal("op13", 4'd13);
        run_illegal("op15", 4'd15);
        run_cmd("nop", 4'd11, 8'h00, 3'b000, 0, 8'h00, 0, 0);

        // Reset during OPER of TAY must abort with no load_y
        run_cmd("lda33", 4'd0, 8'h33, 3'b100, 1, 8'h33, 0, 0);
        begin
            logic [7:0] y_before;
            int ly_before;
            y_before = ry;
            ly_before = load_y_cnt;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 4'd4;
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("tay_in_oper", cmd_ready, 0);
            rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("abort_outs", {reg_data, load_a, load_x, load_y, flag_we, flag_n, flag_z, done, err}, 0);
            end
            rst = 1'b0;
            @(negedge clk);
            chk("abort_rdy", cmd_ready, 1);
            @(negedge clk);
            chk("abort_no_ly", load_y_cnt - ly_before, 0);
            chk("abort_y", ry, y_before);
        end

        // Back-to-back with cmd_valid held high
        ops[0] = 4'd0; dats[0] = 8'h11;
        ops[1] = 4'd3; dats[1] = 8'h00;
`ifdef MOS6502S_REGSEQ_INCDEC_EN
        ops[2] = 4'd7; dats[2] = 8'h00;
        exp_a = 8'h12;
`else
        ops[2] = 4'd2; dats[2] = 8'h22;
        exp_a = 8'h11;
`endif
        ops[3] = 4'd5; dats[3] = 8'h00;
        begin
            int idx, dcnt, cyc;
            idx = 0; dcnt = 0; cyc = 0;
            while (dcnt < 4 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (done) dcnt++;
                if (idx < 4) begin
                    cmd_valid = 1'b1; cmd_op = ops[idx]; cmd_data = dats[idx];
                    if (cmd_ready) begin
                        acc[idx] = cyc;
                        idx++;
                    end
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            cmd_valid = 1'b0;
            chk("b2b_accepts", idx, 4);
            chk("b2b_done", dcnt, 4);
            chk("b2b_gap01", acc[1] - acc[0], 3);
            chk("b2b_gap12", acc[2] - acc[1], 3);
            chk("b2b_gap23", acc[3] - acc[2], 3);
            @(negedge clk);
            chk("b2b_a", ra, exp_a);
            chk("onehot", multi_cnt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mos6502s_reg_sequencer.md
# mos6502s_reg_sequencer

Command sequencer for the 6502 A/X/Y register file. Accepts one register micro-operation at a time over a valid/ready handshake and reads the current A/X/Y values. It computes the result and drives the register file's shared `data_in` bus and per-register load strobes for exactly one cycle. It also produces N/Z flag updates and a completion pulse for the surrounding control unit.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command; high only in IDLE.
- `cmd_op` in 4: operation code (see Operation).
- `cmd_data` in 8: immediate operand for load ops; ignored otherwise.
- `a_in` / `x_in` / `y_in` in 8 each: current register-file outputs.
- `reg_data` out 8: drives register-file `data_in`.
- `load_a` / `load_x` / `load_y` out 1 each: register-file load strobes; at most one high per cycle.
- `flag_we` out 1: N/Z update strobe.
- `flag_n` / `flag_z` out 1 each: N = result[7], Z = (result == 0); valid when `flag_we` is high.
- `done` out 1: one-cycle pulse when a legal op completes.
- `err` out 1: one-cycle pulse when an illegal op is rejected.

## Operation
- Op codes:
  - 0 LDA, 1 LDX, 2 LDY: dest ← cmd_data.
  - 3 TAX, 4 TAY: X/Y ← A.
  - 5 TXA, 6 TYA: A ← X/Y.
  - 7 INX, 8 DEX, 9 INY, 10 DEY: X/Y ± 1, mod 256.
  - 11 NOP: no load, no flags, done.
  - 12–15 illegal.
- FSM states: IDLE, OPER, WRITE.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid` with a legal op: latch op and data → OPER.
  - On `cmd_valid` with an illegal op: pulse `err` next cycle (registered), no load, stay IDLE; `cmd_ready` stays high.
- OPER:
  - Sample `a_in` / `x_in` / `y_in`.
  - Compute the 8-bit result into the result register; select the destination → WRITE.
- WRITE:
  - `reg_data` = result.
  - The destination's `load_*` = 1.
  - `flag_we` = 1 with N/Z, except for NOP, which drives no load and no `flag_we`.
  - `done` = 1 → IDLE.
- Arithmetic wraps: INX with X=0xFF → 0x00, Z=1. DEX with X=0x00 → 0xFF, N=1.
- Outside WRITE:
  - All `load_*`, `flag_we`, `done` = 0.
  - `reg_data` holds its last value (0 after reset).
- Reset:
  - From any state, go to IDLE.
  - Clear all outputs: `reg_data` = 0, strobes = 0, `flag_n` = 0, `flag_z` = 0, `done` = 0, `err` = 0; `cmd_ready` = 1 in the cycle after reset deasserts.
  - A reset during OPER or WRITE aborts the op; no load strobe is issued.
- Commands presented while `cmd_ready` = 0 are not consumed; the requester holds them.

## Timing
- Cycle T: handshake (`cmd_valid` & `cmd_ready`) in IDLE.
- T+1: OPER; `cmd_ready` = 0.
- T+2: WRITE; strobes, `flag_we` and `done` high.
- T+3: IDLE, `cmd_ready` = 1; the register file shows the new value from the T+2 edge.
- Throughput: one command per 3 cycles. Back-to-back dependent ops (TAX then INX) need no hazard logic because the source is sampled in OPER, after the previous WRITE edge.
- `err`: handshake at T with an illegal op → `err` = 1 at T+1; a new command can be accepted at T+1.

## Configuration
- `MOS6502S_REGSEQ_INCDEC_EN` defined: ops 7–10 are legal as above.
- Undefined:
  - Ops 7–10 are treated as illegal (`err` pulse, no load, no flags).
  - The incrementer/decrementer logic is omitted.

## Test plan
- Reset then LDA 0x80: `load_a` = 1 at T+2 with `reg_data` = 0x80, N=1, Z=0, `done` = 1; `cmd_ready` = 0 at T+1..T+2.
- A=0x00 via LDA, then TAX, then TYA with Y=0x5A: `load_x`, `reg_data` = 0x00, Z=1; then `load_a`, 0x5A, N=0, Z=0.
- With the macro: LDX 0xFF, INX → `reg_data` = 0x00, Z=1; DEY with Y=0x00 → 0xFF, N=1. Without the macro: INX → `err` = 1 at T+1, no strobes, `cmd_ready` high.
- Op 13: `err` pulse, no `load_*` or `flag_we` ever asserted; op 11 (NOP): `done` at T+2 with no strobes.
- Assert `rst` during OPER of TAY: no `load_y` pulse, all outputs 0, IDLE with `cmd_ready` = 1 after reset release.
- Hold `cmd_valid` high with 4 queued ops: exactly one accept per 3 cycles, strobes one-hot, `done` count = 4.
